axil_crossbar_port_arb: RTL
===========================

# axil_crossbar_port_arb

Per-master-port admission arbiter for the AXI-lite crossbar. It sits between the S_COUNT per-slave address decoders and one crossbar master interface. It grants the shared address channel round-robin to one requesting source at a time and enforces an outstanding-transaction limit. It keeps an in-order FIFO of granted source indices so that returning B/R responses are steered back to the correct source.

## Interface
- S_COUNT, 4: number of requesting sources (slave interfaces); 1..16
- ACCEPT_LIMIT, 2: max outstanding (address accepted, response not yet done) transactions; 1..16
- CL_S, $clog2(S_COUNT) floored to 1: index width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_req_valid  in  S_COUNT  per-source address valid already decoded to this master
- s_req_ready  out  S_COUNT  per-source address accept, one-hot or zero
- m_avalid  out  1  address valid toward master interface
- m_aready  in  1  master interface accepts address
- m_grant_index  out  CL_S  currently granted source; drives address/prot mux
- m_grant_valid  out  1  grant held
- resp_select  out  CL_S  source owning oldest outstanding transaction (FIFO head)
- resp_select_valid  out  1  FIFO non-empty
- resp_done  in  1  pulse: response handshake for head transaction completed
- outstanding  out  $clog2(ACCEPT_LIMIT+1)  current FIFO occupancy
- err_underflow  out  1  sticky: resp_done seen while FIFO empty

## Operation
- States: IDLE (no grant), GRANT (grant held, waiting for address handshake).
- IDLE -> GRANT when any s_req_valid bit is set and outstanding < ACCEPT_LIMIT (or outstanding == ACCEPT_LIMIT with resp_done the same cycle). Winner: first set bit at or after (last_winner+1) mod S_COUNT, searching upward with wrap. Winner index is registered into m_grant_index.
- GRANT: m_avalid = s_req_valid[m_grant_index]. s_req_ready[m_grant_index] = m_aready && m_avalid, combinational passthrough; all other bits are 0.
- Address handshake (m_avalid && m_aready): push m_grant_index into the FIFO, last_winner <= m_grant_index, return to IDLE.
- GRANT with s_req_valid[m_grant_index] low (protocol violation upstream): drop to IDLE next cycle. No push; last_winner unchanged.
- resp_done with FIFO non-empty: pop the head. resp_done with FIFO empty: ignored, err_underflow <= 1.
- Push and pop in the same cycle: occupancy unchanged, head advances, ordering preserved.
- FIFO: circular, depth ACCEPT_LIMIT. Read/write pointers wrap modulo ACCEPT_LIMIT, including non-power-of-two depths.

## Timing
- Reset values: state IDLE, m_grant_valid 0, m_avalid 0, s_req_ready 0, m_grant_index 0, last_winner S_COUNT-1 (so source 0 wins first), FIFO empty, resp_select_valid 0, resp_select 0, outstanding 0, err_underflow 0.
- Request sampled in cycle N (IDLE, room available) -> m_grant_valid and m_avalid high in cycle N+1.
- Address accepted in cycle N+1 -> grant released in N+2. Earliest next grant is valid in N+3. Peak rate is one address every 2 cycles.
- Push visible on resp_select/outstanding the cycle after the handshake. Pop is visible the cycle after resp_done.
- While full and resp_done is low: no new grant. The room check uses registered occupancy plus same-cycle resp_done.
- rst mid-GRANT or with outstanding entries: everything returns to reset values next cycle. Outstanding transactions are forgotten; the crossbar is reset together with this block.

## Structure
- No shared package is needed. CL_S and the occupancy width are local parameters.
- One natural sub-module: axil_rr_select, combinational round-robin priority select (request vector plus last index -> winner index and valid). It is reusable by the crossbar's R/B return arbitration.
- The FIFO is inline (registers plus pointers). It is too small to justify a separate module.

## Test plan
- Reset, then s_req_valid=4'b0001, m_aready=1 -> m_avalid in cycle 2, s_req_ready=4'b0001 in cycle 2, resp_select=0 and outstanding=1 in cycle 3.
- s_req_valid=4'b1111 held, m_aready=1, resp_done pulsed each push -> grant order 0,1,2,3,0; never two ready bits set.
- ACCEPT_LIMIT=2, no resp_done, source 2 requesting continuously -> two grants, then m_avalid stays 0. One resp_done pulse -> third grant issued on the next arbitration.
- Grants to sources 3 then 1 -> resp_select=3. After resp_done, resp_select=1. After a second resp_done, resp_select_valid=0.
- FIFO full (2 entries) while source 0 requests: resp_done in the arbitration cycle -> grant issued that cycle, outstanding stays 2 after push+pop.
- resp_done with empty FIFO -> err_underflow=1 and stays set. Assert rst mid-GRANT with 1 outstanding -> all outputs return to reset values next cycle, err_underflow cleared.

Source files
------------

// File: rtl/axil_crossbar_port_arb_pkg.sv
// -----------------------------------------------------------------------------
// axil_crossbar_port_arb_pkg
// Shared constants for the per-master-port admission arbiter.
//   ST_IDLE / ST_GRANT : arbiter FSM encodings (also visible on dbg_state)
//   idx_width()        : $clog2 with a floor of 1, used for index widths
// -----------------------------------------------------------------------------
package axil_crossbar_port_arb_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axil_crossbar_port_arb_if.sv
// -----------------------------------------------------------------------------
// axil_crossbar_port_arb_if
// Bundle of all arbiter-side signals between the per-slave decoders, one
// crossbar master interface and the response steering logic.
//   s_req_valid / s_req_ready   : per-source address request / accept
//   m_avalid / m_aready         : address handshake toward the master
//   m_grant_index / valid       : current grant, drives the address mux
//   resp_select / valid         : source owning the oldest outstanding txn
//   resp_done                   : head response finished (pop)
//   outstanding                 : FIFO occupancy
//   err_underflow               : sticky resp_done-while-empty flag
//   dbg_state                   : arbiter FSM state
// Modports: master = side driving requests/aready/resp_done,
//           slave  = the arbiter itself.
//
// Handshake rule: an address transfer happens in a cycle where m_avalid and
// m_aready are both high; s_req_ready mirrors that transfer onto the granted
// source only, so a source sees valid&ready exactly when its address moves.
// -----------------------------------------------------------------------------
interface axil_crossbar_port_arb_if
  import axil_crossbar_port_arb_pkg::*;
#(
  parameter int S_COUNT      = 4,
  parameter int ACCEPT_LIMIT = 2
) ();

  localparam int CL_S  = idx_width(S_COUNT);
  localparam int OCC_W = $clog2(ACCEPT_LIMIT + 1);

  logic [S_COUNT-1:0] s_req_valid;
  logic [S_COUNT-1:0] s_req_ready;
  logic               m_avalid;
  logic               m_aready;
  logic [CL_S-1:0]    m_grant_index;
  logic               m_grant_valid;
  logic [CL_S-1:0]    resp_select;
  logic               resp_select_valid;
  logic               resp_done;
  logic [OCC_W-1:0]   outstanding;
  logic               err_underflow;
  logic [0:0]         dbg_state;

  modport master (
    output s_req_valid, m_aready, resp_done,
    input  s_req_ready, m_avalid, m_grant_index, m_grant_valid,
           resp_select, resp_select_valid, outstanding, err_underflow,
           dbg_state
  );

  modport slave (
    input  s_req_valid, m_aready, resp_done,
    output s_req_ready, m_avalid, m_grant_index, m_grant_valid,
           resp_select, resp_select_valid, outstanding, err_underflow,
           dbg_state
  );

endinterface

// File: rtl/axil_rr_select.sv
// -----------------------------------------------------------------------------
// axil_rr_select
// Combinational round-robin priority select. Picks the first set request bit
// at or after (i_last+1) mod N, searching upward with wrap.
//   i_req   : request vector
//   i_last  : index of the previous winner
//   o_idx   : winner index (0 when nothing requests)
//   o_valid : at least one request set
// -----------------------------------------------------------------------------
module axil_rr_select #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  // Each request gets a distance from the slot right after i_last; the
  // smallest distance wins. Indexing only with the loop constant keeps the
  // selects static.
  always_comb begin
    int w_best;
    int w_dist;
    w_best  = N;
    w_dist  = 0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int j = 0; j < N; j++) begin
      w_dist = (j + N - 1 - int'(i_last)) % N;
      if (i_req[j] && (w_dist < w_best)) begin
        w_best  = w_dist;
        o_idx   = IW'(j);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axil_crossbar_port_arb.sv
// -----------------------------------------------------------------------------
// axil_crossbar_port_arb
// Per-master-port admission arbiter. Grants the shared address channel
// round-robin to one source at a time, limits outstanding transactions to
// ACCEPT_LIMIT and keeps an in-order FIFO of granted sources so responses can
// be steered back.
//   clk, rst : clock, synchronous active-high reset
//   bus      : axil_crossbar_port_arb_if.slave (see interface header)
// -----------------------------------------------------------------------------
module axil_crossbar_port_arb
  import axil_crossbar_port_arb_pkg::*;
#(
  parameter int S_COUNT      = 4,
  parameter int ACCEPT_LIMIT = 2
) (
  input logic                    clk,
  input logic                    rst,
  axil_crossbar_port_arb_if.slave bus
);

  localparam int CL_S  = idx_width(S_COUNT);
  localparam int OCC_W = $clog2(ACCEPT_LIMIT + 1);
  localparam int PTR_W = idx_width(ACCEPT_LIMIT);

  localparam logic [OCC_W-1:0] LIMIT    = OCC_W'(ACCEPT_LIMIT);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(ACCEPT_LIMIT - 1);

  logic [0:0]       r_state;
  logic [CL_S-1:0]  r_grant_idx;
  logic [CL_S-1:0]  r_last;
  logic [CL_S-1:0]  r_fifo [ACCEPT_LIMIT];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_count;
  logic             r_err;

  logic [CL_S-1:0]    w_sel_idx;
  logic               w_sel_valid;
  logic               w_room;
  logic               w_src_valid;
  logic               w_avalid;
  logic               w_hs;
  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic [S_COUNT-1:0] w_ready;

  axil_rr_select #(
    .N  (S_COUNT),
    .IW (CL_S)
  ) u_rr_select (
    .i_req   (bus.s_req_valid),
    .i_last  (r_last),
    .o_idx   (w_sel_idx),
    .o_valid (w_sel_valid)
  );

  assign w_empty = (r_count == '0);
  // A full FIFO still admits a grant when the head pops this same cycle.
  assign w_room      = (r_count < LIMIT) || bus.resp_done;
  assign w_src_valid = bus.s_req_valid[r_grant_idx];
  assign w_avalid    = (r_state == ST_GRANT) && w_src_valid;
  assign w_hs        = w_avalid && bus.m_aready;
  assign w_push      = w_hs;
  assign w_pop       = bus.resp_done && !w_empty;

  always_comb begin
    w_ready = '0;
    if (w_hs) w_ready[r_grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_grant_idx <= '0;
      r_last      <= CL_S'(S_COUNT - 1);
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_sel_valid && w_room) begin
            r_state     <= ST_GRANT;
            r_grant_idx <= w_sel_idx;
          end
        end
        ST_GRANT: begin
          if (w_hs) begin
            r_state <= ST_IDLE;
            r_last  <= r_grant_idx;
          end else if (!w_src_valid) begin
            // Source withdrew its request: release without touching priority.
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (bus.resp_done && w_empty) r_err <= 1'b1;
    end
  end

  // Entry storage needs no reset: it is only observed through the gated head.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= r_grant_idx;
  end

  assign bus.s_req_ready       = w_ready;
  assign bus.m_avalid          = w_avalid;
  assign bus.m_grant_index     = r_grant_idx;
  assign bus.m_grant_valid     = (r_state == ST_GRANT);
  assign bus.resp_select       = w_empty ? '0 : r_fifo[r_rd_ptr];
  assign bus.resp_select_valid = !w_empty;
  assign bus.outstanding       = r_count;
  assign bus.err_underflow     = r_err;
  assign bus.dbg_state         = r_state;

endmodule
